// File: rtl/bus_seq_serializer.sv
// Bus word serializer: steps through NUM_INPUTS words of BUS_WIDTH bits,
// one word per select_line phase (MODE 0/1) or per fixed-length pulse (MODE 2).
// index and wrap are registered; y and y_valid are combinational views of them.
module bus_seq_serializer #(
  parameter int NUM_INPUTS  = 16,
  parameter int BUS_WIDTH   = 4,
  parameter int PULSE_WIDTH = 8,
  parameter int MODE        = 0,
  localparam int IDX_W      = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1,
  localparam int PW_W       = $clog2(PULSE_WIDTH + 1)
) (
  input  logic                                 aclk,
  input  logic                                 grst,
  input  logic [NUM_INPUTS-1:0][BUS_WIDTH-1:0] inputs,
  input  logic                                 select_line,
  input  logic                                 enable,
  input  logic                                 sync_clear,
  output logic [BUS_WIDTH-1:0]                 y,
  output logic                                 y_valid,
  output logic [IDX_W-1:0]                     index,
  output logic                                 wrap
);

  // Reject unsupported configurations at elaboration time.
  if ((MODE < 0) || (MODE > 2) || (NUM_INPUTS < 2) || (NUM_INPUTS > 1024) ||
      (BUS_WIDTH < 1) || (PULSE_WIDTH < 1) || (PULSE_WIDTH > 255)) begin : g_bad_param
    $error("bus_seq_serializer: illegal parameter combination");
  end

  logic                 sel_q;
  logic [PW_W-1:0]      pcnt_q, pcnt_d;
  logic [IDX_W-1:0]     index_q, index_d;
  logic                 wrap_q, wrap_d;
  logic                 rise_s, fall_s;
  logic                 valid_s, adv_s, last_s;

  // Phase edge detection and per-mode valid/advance decode.
  always_comb begin
    rise_s  = select_line & ~sel_q;
    fall_s  = ~select_line & sel_q;
    valid_s = 1'b0;
    adv_s   = 1'b0;
    case (MODE)
      0: begin
        valid_s = enable & select_line;
        adv_s   = enable & fall_s;
      end
      1: begin
        valid_s = enable & ~select_line;
        adv_s   = enable & rise_s;
      end
      2: begin
        valid_s = enable & (pcnt_q != {PW_W{1'b0}});
        adv_s   = enable & (pcnt_q == PW_W'(1));
      end
      default: begin
        valid_s = 1'b0;
        adv_s   = 1'b0;
      end
    endcase
  end

  // Pulse counter: starts only when idle, so a rise mid-pulse is dropped.
  always_comb begin
    pcnt_d = pcnt_q;
    if (sync_clear) begin
      pcnt_d = {PW_W{1'b0}};
    end else if ((MODE == 2) && enable) begin
      if (pcnt_q != {PW_W{1'b0}}) begin
        pcnt_d = pcnt_q - PW_W'(1);
      end else if (rise_s) begin
        pcnt_d = PW_W'(PULSE_WIDTH);
      end else begin
        pcnt_d = pcnt_q;
      end
    end else begin
      pcnt_d = pcnt_q;
    end
  end

  // Index advance with explicit wrap so non-power-of-two counts stay in range.
  always_comb begin
    last_s  = (index_q == IDX_W'(NUM_INPUTS - 1));
    index_d = index_q;
    wrap_d  = 1'b0;
    if (sync_clear) begin
      index_d = {IDX_W{1'b0}};
      wrap_d  = 1'b0;
    end else if (adv_s) begin
      index_d = last_s ? {IDX_W{1'b0}} : (index_q + IDX_W'(1));
      wrap_d  = last_s;
    end else begin
      index_d = index_q;
      wrap_d  = 1'b0;
    end
  end

  // State registers; sel_q tracks select_line every cycle, even when frozen.
  always_ff @(posedge aclk or posedge grst) begin
    if (grst) begin
      sel_q   <= 1'b0;
      pcnt_q  <= {PW_W{1'b0}};
      index_q <= {IDX_W{1'b0}};
      wrap_q  <= 1'b0;
    end else begin
      sel_q   <= select_line;
      pcnt_q  <= pcnt_d;
      index_q <= index_d;
      wrap_q  <= wrap_d;
    end
  end

  // Output word is the live input selected by the registered index.
  always_comb begin
    if (valid_s) begin
      y = inputs[index_q];
    end else begin
      y = {BUS_WIDTH{1'b0}};
    end
    y_valid = valid_s;
    index   = index_q;
    wrap    = wrap_q;
  end

endmodule

// File: tb/tb_bus_seq_serializer.sv
// Self-checking bench: three serializer instances (rising-phase with 16 words,
// falling-phase with 5 words, pulse mode with width 3) against a queue-free
// behavioural model of word position and remaining pulse length.
module tb_bus_seq_serializer;

  localparam int PW = 3;
  localparam int NN [3] = '{16, 5, 16};

  logic aclk = 1'b0;
  always #5 aclk = ~aclk;

  logic grst;
  logic sel [3];
  logic en  [3];
  logic clr [3];
  logic [15:0][3:0] d0, d2;
  logic [4:0][3:0]  d1;
  logic [3:0] y0, y1, y2;
  logic v0, v1, v2, w0, w1, w2;
  logic [3:0] ix0, ix2;
  logic [2:0] ix1;

  int pass_cnt = 0;
  int total_cnt = 0;

  int m_idx [3];
  int m_rem [3];
  bit m_prev [3];
  bit m_wrap [3];

  bus_seq_serializer #(.NUM_INPUTS(16), .BUS_WIDTH(4), .PULSE_WIDTH(8), .MODE(0)) u0 (
    .aclk(aclk), .grst(grst), .inputs(d0), .select_line(sel[0]), .enable(en[0]),
    .sync_clear(clr[0]), .y(y0), .y_valid(v0), .index(ix0), .wrap(w0));

  bus_seq_serializer #(.NUM_INPUTS(5), .BUS_WIDTH(4), .PULSE_WIDTH(8), .MODE(1)) u1 (
    .aclk(aclk), .grst(grst), .inputs(d1), .select_line(sel[1]), .enable(en[1]),
    .sync_clear(clr[1]), .y(y1), .y_valid(v1), .index(ix1), .wrap(w1));

  bus_seq_serializer #(.NUM_INPUTS(16), .BUS_WIDTH(4), .PULSE_WIDTH(PW), .MODE(2)) u2 (
    .aclk(aclk), .grst(grst), .inputs(d2), .select_line(sel[2]), .enable(en[2]),
    .sync_clear(clr[2]), .y(y2), .y_valid(v2), .index(ix2), .wrap(w2));

  function automatic logic [3:0] word_of(input int i, input int k);
    case (i)
      0:       return d0[k];
      1:       return d1[k];
      default: return d2[k];
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_idx[i] = 0; m_rem[i] = 0; m_prev[i] = 1'b0; m_wrap[i] = 1'b0;
    end
  endtask

  // One clock edge of the reference: count words, count remaining pulse cycles.
  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      bit adv;
      bit rise;
      bit fall;
      adv  = 1'b0;
      rise = sel[i] && !m_prev[i];
      fall = !sel[i] && m_prev[i];
      if (i == 0) adv = en[i] && fall;
      else if (i == 1) adv = en[i] && rise;
      else begin
        if (en[i] && m_rem[i] > 0) begin
          m_rem[i] = m_rem[i] - 1;
          adv = (m_rem[i] == 0);
        end else if (en[i] && rise) begin
          m_rem[i] = PW;
        end
      end
      if (clr[i]) begin
        m_idx[i] = 0; m_rem[i] = 0; m_wrap[i] = 1'b0;
      end else begin
        m_wrap[i] = adv && (m_idx[i] == NN[i] - 1);
        if (adv) m_idx[i] = (m_idx[i] + 1) % NN[i];
      end
      m_prev[i] = sel[i];
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      bit exp_v;
      logic [3:0] exp_y;
      logic [3:0] oy;
      logic ov, ow;
      int oi;
      if (i == 0) exp_v = en[i] && sel[i];
      else if (i == 1) exp_v = en[i] && !sel[i];
      else exp_v = en[i] && (m_rem[i] > 0);
      exp_y = exp_v ? word_of(i, m_idx[i]) : 4'h0;
      case (i)
        0:       begin oy = y0; ov = v0; ow = w0; oi = int'(ix0); end
        1:       begin oy = y1; ov = v1; ow = w1; oi = int'(ix1); end
        default: begin oy = y2; ov = v2; ow = w2; oi = int'(ix2); end
      endcase
      chk($sformatf("u%0d y", i), 32'(oy), 32'(exp_y));
      chk($sformatf("u%0d y_valid", i), 32'(ov), 32'(exp_v));
      chk($sformatf("u%0d index", i), 32'(oi), 32'(m_idx[i]));
      chk($sformatf("u%0d wrap", i), 32'(ow), 32'(m_wrap[i]));
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    int seq1 [7];
    int guard;
    seq1 = '{1, 2, 3, 4, 0, 1, 2};
    grst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sel[i] = 1'b0; en[i] = 1'b0; clr[i] = 1'b0;
    end
    for (int k = 0; k < 16; k++) begin
      d0[k] = 4'(k);
      d2[k] = 4'($urandom_range(0, 15));
    end
    for (int k = 0; k < 5; k++) d1[k] = 4'($urandom_range(0, 15));
    d2[0] = 4'hA;
    model_reset();
    #12;
    check_all();
    // Phase modes keep following select_line while held in reset.
    en[0] = 1'b1; sel[0] = 1'b1;
    #1;
    chk("rst mode0 y_valid", 32'(v0), 32'd1);
    chk("rst mode0 y", 32'(y0), 32'(d0[0]));
    sel[0] = 1'b0;
    grst = 1'b0;

    // Rising-phase: 16 high/low phases walk words 0..15 then wrap.
    for (int k = 0; k < 16; k++) begin
      sel[0] = 1'b1; tick();
      chk("seq0 word", 32'(y0), 32'(k));
      tick();
      sel[0] = 1'b0; tick();
    end
    chk("seq0 wrap", 32'(w0), 32'd1);
    chk("seq0 index0", 32'(ix0), 32'd0);
    tick();
    chk("seq0 wrap drop", 32'(w0), 32'd0);

    // Falling-phase with 5 words: index advances on each rise.
    en[1] = 1'b1;
    for (int r = 0; r < 7; r++) begin
      sel[1] = 1'b1; tick();
      chk("seq1 index", 32'(ix1), 32'(seq1[r]));
      chk("seq1 wrap", 32'(w1), (r == 4) ? 32'd1 : 32'd0);
      sel[1] = 1'b0; tick();
    end

    // Pulse: 3 valid cycles of word 0, a rise inside the pulse is ignored.
    en[2] = 1'b1;
    sel[2] = 1'b1; tick();
    chk("pulse c1", 32'(y2), 32'hA);
    sel[2] = 1'b0; tick();
    chk("pulse c2", 32'(y2), 32'hA);
    sel[2] = 1'b1; tick();
    chk("pulse c3", 32'(y2), 32'hA);
    tick();
    chk("pulse end y", 32'(y2), 32'h0);
    chk("pulse end index", 32'(ix2), 32'd1);
    tick();
    chk("pulse no restart", 32'(v2), 32'd0);
    sel[2] = 1'b0; tick();

    // Enable gap with two cycles left in the pulse.
    sel[2] = 1'b1; tick();
    sel[2] = 1'b0; tick();
    en[2] = 1'b0;
    for (int g = 0; g < 4; g++) begin
      tick();
      chk("gap y", 32'(y2), 32'h0);
    end
    en[2] = 1'b1;
    #1;
    chk("resume valid", 32'(v2), 32'd1);
    d2[1] = d2[1] ^ 4'hF;
    #1;
    chk("live input", 32'(y2), 32'(d2[1]));
    tick();
    chk("resume c2", 32'(v2), 32'd1);
    tick();
    chk("resume done", 32'(v2), 32'd0);
    chk("resume index", 32'(ix2), 32'd2);

    // Clear on the same edge as a wrap.
    guard = 0;
    while (m_idx[1] != 4 && guard < 20) begin
      sel[1] = 1'b1; tick();
      sel[1] = 1'b0; tick();
      guard++;
    end
    chk("reach idx4", 32'(ix1), 32'd4);
    sel[1] = 1'b1; clr[1] = 1'b1; tick();
    chk("clr index", 32'(ix1), 32'd0);
    chk("clr wrap", 32'(w1), 32'd0);
    clr[1] = 1'b0; sel[1] = 1'b0; tick();

    // Reset in the middle of a pulse at word 7.
    guard = 0;
    while (m_idx[2] != 7 && guard < 40) begin
      sel[2] = 1'b1; tick();
      sel[2] = 1'b0; repeat (3) tick();
      guard++;
    end
    chk("reach idx7", 32'(ix2), 32'd7);
    sel[2] = 1'b1; tick();
    tick();
    grst = 1'b1;
    #1;
    chk("async y", 32'(y2), 32'h0);
    chk("async valid", 32'(v2), 32'd0);
    chk("async wrap", 32'(w2), 32'd0);
    chk("async index", 32'(ix2), 32'd0);
    model_reset();
    #3;
    grst = 1'b0;
    tick();
    chk("post rst pulse", 32'(y2), 32'hA);

    // Random traffic on all three instances.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 3; i++) begin
        if ($urandom_range(0, 2) == 0) sel[i] = ~sel[i];
        en[i]  = ($urandom_range(0, 7) != 0);
        clr[i] = ($urandom_range(0, 40) == 0);
      end
      if ($urandom_range(0, 3) == 0) begin
        d0[$urandom_range(0, 15)] = 4'($urandom_range(0, 15));
        d1[$urandom_range(0, 4)]  = 4'($urandom_range(0, 15));
        d2[$urandom_range(0, 15)] = 4'($urandom_range(0, 15));
      end
      tick();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/bus_seq_serializer.md
BUS_SEQ_SERIALIZER -- requirements
Module: bus_seq_serializer

Interface
REQ-001 SHALL have parameter NUM_INPUTS, default 16: number of bus words serialized per sequence (legal 2..1024).
REQ-002 SHALL have parameter BUS_WIDTH, default 4: bits per word (legal >= 1).
REQ-003 SHALL have parameter PULSE_WIDTH, default 8: active cycles per word in pulse mode (legal 1..255).
REQ-004 SHALL have parameter MODE, default 0: 0 = rising-phase, 1 = falling-phase, 2 = pulse-width; any other value or illegal parameter SHALL fail elaboration.
REQ-005 SHALL define IDX_W = max(1, clog2(NUM_INPUTS)) and PW_W = clog2(PULSE_WIDTH+1).
REQ-006 aclk  input  1  clock, all state on rising edge.
REQ-007 grst  input  1  reset, asynchronous, active-high.
REQ-008 inputs  input  NUM_INPUTS x BUS_WIDTH  packed word array, word 0 sent first.
REQ-009 select_line  input  1  gamma phase signal, synchronous to aclk.
REQ-010 enable  input  1  high = serialize; low = freeze.
REQ-011 sync_clear  input  1  synchronous restart at word 0.
REQ-012 y  output  BUS_WIDTH  serialized word, zero when not valid.
REQ-013 y_valid  output  1  high when y carries inputs[index].
REQ-014 index  output  IDX_W  current word index, registered.
REQ-015 wrap  output  1  one-cycle registered pulse at sequence completion.

Function
REQ-016 SHALL register select_line into sel_q each cycle regardless of enable; rise = select_line & ~sel_q, fall = ~select_line & sel_q.
REQ-017 MODE 0: y_valid = enable & select_line (combinational); index SHALL advance on the clock edge where fall & enable.
REQ-018 MODE 1: y_valid = enable & ~select_line (combinational); index SHALL advance on the clock edge where rise & enable.
REQ-019 MODE 2: pulse counter pcnt (PW_W bits); y_valid = enable & (pcnt != 0).
REQ-020 MODE 2: rise & enable & pcnt==0 SHALL load pcnt = PULSE_WIDTH; rise while pcnt != 0 SHALL be ignored (no restart, no queueing).
REQ-021 MODE 2: while enable & pcnt != 0, pcnt SHALL decrement by 1 per cycle; index SHALL advance on the edge where pcnt goes 1 -> 0.
REQ-022 Result: in MODE 2, y is valid for exactly PULSE_WIDTH consecutive cycles starting the cycle after rise is sampled.
REQ-023 y SHALL equal inputs[index] when y_valid, else all zeros.
REQ-024 Advance SHALL be index+1, wrapping NUM_INPUTS-1 -> 0 for any NUM_INPUTS (including non-powers of two); index SHALL never exceed NUM_INPUTS-1.
REQ-025 wrap SHALL be high for exactly the one cycle after the edge on which index wraps to 0; otherwise low.
REQ-026 enable low SHALL hold index and pcnt, force y_valid=0 and y=0, and suppress wrap; resuming continues from held state.
REQ-027 sync_clear SHALL set index=0, pcnt=0, wrap=0 on the next edge, with priority over any simultaneous advance, pulse start or wrap; sel_q still updates.
REQ-028 inputs SHALL be sampled combinationally; a change to inputs while valid appears on y the same cycle.

Reset
REQ-029 grst high SHALL immediately set index=0, pcnt=0, sel_q=0, wrap=0; y=0 and y_valid=0 in MODE 2, and in MODES 0/1 y_valid follows select_line and enable per REQ-017/018 with y=inputs[0].
REQ-030 grst asserted mid-pulse or mid-sequence SHALL abandon it; first activity after release restarts at word 0.
REQ-031 Since sel_q resets to 0, select_line high at grst release SHALL count as a rise on the first clock edge.

Verification
REQ-032 MODE 0, NUM_INPUTS=16, inputs[k]=k: 16 select_line high/low phases -> y=0..15 during high phases, 0 during low, wrap high once after 16th fall, index=0.
REQ-033 MODE 1, NUM_INPUTS=5: 7 select_line rises -> index sequence 1,2,3,4,0,1,2; wrap pulses once, one cycle after the 5th rise edge.
REQ-034 MODE 2, PULSE_WIDTH=3, inputs[0]=0xA: single rise -> y=0xA for exactly 3 cycles starting next cycle, then 0; index 0 -> 1 on last pulse edge; a second rise during the pulse is ignored.
REQ-035 MODE 2, enable dropped for 4 cycles mid-pulse with pcnt=2 -> y=0 during gap, pcnt held; after re-enable y valid 2 more cycles.
REQ-036 sync_clear asserted on the same edge as an index wrap (index=NUM_INPUTS-1) -> index=0, wrap stays 0.
REQ-037 grst asserted mid-pulse at index=7 -> y, y_valid, wrap, index zero immediately without a clock; released with select_line high -> MODE 2 pulse starts for word 0.
